// File: rtl/sram_cluster_read_port.sv
// Read port for a cluster of byte-wide SRAM banks: issue, latency track, compact, buffer.
// Optional per-bank even parity check when SRAM_CLUSTER_PARITY_EN is defined.
module sram_cluster_read_port #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int DEPTH     = RD_LAT + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NUM_BANKS-1:0]          req_mask,
  output logic [NUM_BANKS-1:0]          sram_csb,
  input  logic [NUM_BANKS*BANK_W-1:0]   d_sram,
`ifdef SRAM_CLUSTER_PARITY_EN
  input  logic [NUM_BANKS-1:0]          p_sram,
  output logic                          rsp_perr,
`endif
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_BANKS*BANK_W-1:0]   rsp_data,
  output logic [$clog2(NUM_BANKS+1)-1:0] rsp_lanes
);

  localparam int DW = NUM_BANKS * BANK_W;
  localparam int LW = $clog2(NUM_BANKS + 1);
  localparam int CW = $clog2(DEPTH + RD_LAT + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [RD_LAT-1:0]                vld_q, vld_d;
  logic [RD_LAT-1:0][NUM_BANKS-1:0] msk_q, msk_d;
  logic [DW-1:0] dat_mem_q [DEPTH];
  logic [DW-1:0] dat_mem_d [DEPTH];
  logic [LW-1:0] lan_mem_q [DEPTH];
  logic [LW-1:0] lan_mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] last_data_q, last_data_d;
  logic [LW-1:0] last_lanes_q, last_lanes_d;

  logic          fire, issue, push, pop;
  logic [CW-1:0] inflight;
  logic [DW-1:0] comp_data;
  logic [LW-1:0] comp_lanes;

`ifdef SRAM_CLUSTER_PARITY_EN
  logic perr_mem_q [DEPTH];
  logic perr_mem_d [DEPTH];
  logic last_perr_q, last_perr_d;
  logic comp_perr;
`endif

  // Credits count everything not yet popped, from registered state only
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
  end

  assign req_ready = !rst && ((inflight + cnt_q) < CW'(DEPTH));
  assign fire      = req_valid && req_ready;
  assign issue     = fire && (|req_mask);
  assign sram_csb  = issue ? ~req_mask : '1;

  assign push      = vld_q[RD_LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    int k;
    k         = 0;
    comp_data = '0;
`ifdef SRAM_CLUSTER_PARITY_EN
    comp_perr = 1'b0;
`endif
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (msk_q[RD_LAT-1][i]) begin
        comp_data[k*BANK_W +: BANK_W] = d_sram[i*BANK_W +: BANK_W];
        k = k + 1;
`ifdef SRAM_CLUSTER_PARITY_EN
        comp_perr = comp_perr | (^d_sram[i*BANK_W +: BANK_W] ^ p_sram[i]);
`endif
      end
    end
    comp_lanes = LW'(k);
  end

  always_comb begin
    vld_d        = '0;
    msk_d        = '0;
    vld_d[0]     = issue;
    msk_d[0]     = req_mask;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      msk_d[i] = msk_q[i-1];
    end
    dat_mem_d    = dat_mem_q;
    lan_mem_d    = lan_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_data_d  = last_data_q;
    last_lanes_d = last_lanes_q;
    cnt_d        = cnt_q + CW'(push) - CW'(pop);
`ifdef SRAM_CLUSTER_PARITY_EN
    perr_mem_d   = perr_mem_q;
    last_perr_d  = last_perr_q;
`endif
    if (push) begin
      dat_mem_d[wr_ptr_q] = comp_data;
      lan_mem_d[wr_ptr_q] = comp_lanes;
`ifdef SRAM_CLUSTER_PARITY_EN
      perr_mem_d[wr_ptr_q] = comp_perr;
`endif
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    // Remember the popped head so an empty FIFO keeps showing it
    if (pop) begin
      last_data_d  = dat_mem_q[rd_ptr_q];
      last_lanes_d = lan_mem_q[rd_ptr_q];
`ifdef SRAM_CLUSTER_PARITY_EN
      last_perr_d  = perr_mem_q[rd_ptr_q];
`endif
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  assign rsp_data  = rsp_valid ? dat_mem_q[rd_ptr_q] : last_data_q;
  assign rsp_lanes = rsp_valid ? lan_mem_q[rd_ptr_q] : last_lanes_q;
`ifdef SRAM_CLUSTER_PARITY_EN
  assign rsp_perr  = rsp_valid ? perr_mem_q[rd_ptr_q] : last_perr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      msk_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_data_q  <= '0;
      last_lanes_q <= '0;
`ifdef SRAM_CLUSTER_PARITY_EN
      last_perr_q  <= 1'b0;
`endif
    end else begin
      vld_q        <= vld_d;
      msk_q        <= msk_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      last_data_q  <= last_data_d;
      last_lanes_q <= last_lanes_d;
`ifdef SRAM_CLUSTER_PARITY_EN
      last_perr_q  <= last_perr_d;
`endif
    end
  end

  // Storage needs no reset: it is only observed while the count is non-zero
  always_ff @(posedge clk) begin
    dat_mem_q <= dat_mem_d;
    lan_mem_q <= lan_mem_d;
`ifdef SRAM_CLUSTER_PARITY_EN
    perr_mem_q <= perr_mem_d;
`endif
  end

endmodule
